// File: rtl/multi_booth_pkg.sv
// Shared types for the radix-4 Booth multiplier.
//   state_e       : controller states (IDLE, RUN, DONE)
//   booth_digit_t : one recoded digit as sign + magnitude one-hot (0, 1 or 2)
//   booth_digits  : digit count N for a given operand width
package multi_booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Magnitude is one-hot: {one,two} = 00 -> 0, 10 -> 1, 01 -> 2.
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_digit_t;

  // WIDTH/2 digits cover the operand, plus one more for the extension bits
  // so unsigned operands with the top bit set are recoded correctly.
  function automatic int unsigned booth_digits(input int unsigned width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/multi_booth_r4_if.sv
// Operand/result bundle for multi_booth_r4.
//   start        : request, sampled only when the multiplier is not busy
//   signed_mode  : 1 = two's-complement operands, 0 = unsigned
//   a, b         : multiplier / multiplicand (WIDTH bits)
//   acc_clr      : only with MULTI_BOOTH_ACC_EN; 1 = start a fresh accumulation
//   p            : product register (2*WIDTH bits)
//   rdy          : result valid, held until the next accepted start
//   busy         : operation in progress
// Modports: master drives requests, slave is the multiplier.
interface multi_booth_r4_if #(
  parameter int unsigned WIDTH = 8
);

  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [2*WIDTH-1:0]   p;
  logic                 rdy;
  logic                 busy;
`ifdef MULTI_BOOTH_ACC_EN
  logic                 acc_clr;

  modport master (output start, signed_mode, a, b, acc_clr, input p, rdy, busy);
  modport slave  (input start, signed_mode, a, b, acc_clr, output p, rdy, busy);
`else
  modport master (output start, signed_mode, a, b, input p, rdy, busy);
  modport slave  (input start, signed_mode, a, b, output p, rdy, busy);
`endif

endinterface

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth recoder (combinational).
//   bits_i  : {m[2i+1], m[2i], m[2i-1]}
//   digit_o : d = -2*m[2i+1] + m[2i] + m[2i-1] as sign + one-hot magnitude
module booth_r4_enc
  import multi_booth_pkg::*;
(
  input  logic [2:0]   bits_i,
  output booth_digit_t digit_o
);

  always_comb begin
    digit_o     = '0;
    digit_o.one = bits_i[1] ^ bits_i[0];
    digit_o.two = (bits_i[2] & ~bits_i[1] & ~bits_i[0]) |
                  (~bits_i[2] & bits_i[1] & bits_i[0]);
    // 111 encodes zero, so it must not carry a sign
    digit_o.neg = bits_i[2] & ~(bits_i[1] & bits_i[0]);
  end

endmodule

// File: rtl/multi_booth_r4.sv
// Sequential radix-4 Booth multiplier, one Booth digit per clock.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous, active-low reset
//   bus     : multi_booth_r4_if slave modport (start/operands in, p/rdy/busy out)
// Parameter WIDTH: operand width, even and >= 4; product is 2*WIDTH bits.
// A result takes N = WIDTH/2+1 cycles after the accept edge; a new start is
// accepted in IDLE or DONE, start while running is ignored.
// Define MULTI_BOOTH_ACC_EN for multiply-accumulate: acc_clr is captured with
// start and the completion writes p <= (acc_clr ? 0 : p) + product.
module multi_booth_r4
  import multi_booth_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic              clk,
  input logic              reset_n,
  multi_booth_r4_if.slave  bus
);

  localparam int unsigned N  = booth_digits(WIDTH);
  localparam int unsigned CW = $clog2(N);
  localparam int unsigned AW = 2 * WIDTH + 2;  // accumulator / multiplicand
  localparam int unsigned MW = WIDTH + 3;      // extended multiplier + m[-1]

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [MW-1:0]    mplier_q, mplier_d;
  logic [AW-1:0]    mcand_q, mcand_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [2*WIDTH-1:0] p_q, p_d;
`ifdef MULTI_BOOTH_ACC_EN
  logic             acc_clr_q, acc_clr_d;
`endif

  booth_digit_t     digit;
  logic [AW-1:0]    pp;
  logic [AW-1:0]    acc_next;
  logic             sx_a, sx_b;

  // The multiplier register shifts right by two each digit, so the current
  // digit window is always its three low bits.
  booth_r4_enc u_enc (
    .bits_i  (mplier_q[2:0]),
    .digit_o (digit)
  );

  // The multiplicand register shifts left by two each digit, so it already
  // carries the 4^i weight of the current digit.
  always_comb begin
    pp = '0;
    if (digit.two) begin
      pp = mcand_q << 1;
    end else if (digit.one) begin
      pp = mcand_q;
    end
    acc_next = digit.neg ? (acc_q - pp) : (acc_q + pp);
  end

  assign sx_a = bus.signed_mode & bus.a[WIDTH-1];
  assign sx_b = bus.signed_mode & bus.b[WIDTH-1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    p_d      = p_q;
`ifdef MULTI_BOOTH_ACC_EN
    acc_clr_d = acc_clr_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d  = RUN;
          cnt_d    = '0;
          mplier_d = {{2{sx_a}}, bus.a, 1'b0};
          mcand_d  = {{(WIDTH + 2){sx_b}}, bus.b};
          acc_d    = '0;
`ifdef MULTI_BOOTH_ACC_EN
          acc_clr_d = bus.acc_clr;
`endif
        end
      end
      RUN: begin
        acc_d    = acc_next;
        mplier_d = mplier_q >> 2;
        mcand_d  = mcand_q << 2;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          // Last digit: the product is taken from acc_next directly so the
          // result lands on the same edge as the final accumulation.
          state_d = DONE;
          cnt_d   = cnt_q;
`ifdef MULTI_BOOTH_ACC_EN
          p_d = (acc_clr_q ? '0 : p_q) + acc_next[2*WIDTH-1:0];
`else
          p_d = acc_next[2*WIDTH-1:0];
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      p_q      <= '0;
`ifdef MULTI_BOOTH_ACC_EN
      acc_clr_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      p_q      <= p_d;
`ifdef MULTI_BOOTH_ACC_EN
      acc_clr_q <= acc_clr_d;
`endif
    end
  end

  assign bus.p    = p_q;
  assign bus.busy = (state_q == RUN);
  assign bus.rdy  = (state_q == DONE);

endmodule

// File: tb/tb_multi_booth_r4.sv
// Scoreboard bench for multi_booth_r4 at WIDTH=8 and WIDTH=16.
// Stimulus tasks push the expected product (integer arithmetic model) into a
// per-instance queue; monitors pop and compare on each rising rdy, and check
// that p holds the last retired value while busy.
module tb_multi_booth_r4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  multi_booth_r4_if #(.WIDTH(8))  if8 ();
  multi_booth_r4_if #(.WIDTH(16)) if16 ();

  multi_booth_r4 #(.WIDTH(8)) dut8 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if8.slave)
  );

  multi_booth_r4 #(.WIDTH(16)) dut16 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if16.slave)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] q8[$];
  logic [31:0] q16[$];
  logic [31:0] ret8, ret16;   // value p should hold (last retired)
  logic [31:0] pm8, pm16;     // model of p after all issued operations
  logic        rdy8_prev, rdy16_prev;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  // Exact product from plain integer arithmetic, reduced to 2*w bits.
  function automatic logic [31:0] ref_prod(input int unsigned w, input logic sm,
                                           input logic [15:0] a, input logic [15:0] b);
    longint sa, sb, prod, mask;
    sa = longint'(a);
    sb = longint'(b);
    if (sm && a[w-1]) sa = sa - (longint'(1) << w);
    if (sm && b[w-1]) sb = sb - (longint'(1) << w);
    prod = sa * sb;
    mask = (longint'(1) << (2 * w)) - 1;
    return 32'(prod & mask);
  endfunction

  function automatic logic [15:0] pick(input int unsigned w);
    logic [15:0] msk, r;
    msk = 16'((32'd1 << w) - 1);
    case ($urandom_range(0, 5))
      0:       r = '0;
      1:       r = msk;
      2:       r = 16'(32'd1 << (w - 1));
      3:       r = msk >> 1;
      default: r = 16'($urandom);
    endcase
    return r & msk;
  endfunction

  always @(negedge clk) begin
    if (reset_n) begin
      if (if8.rdy && !rdy8_prev) begin
        if (q8.size() == 0) begin
          checks++; failures++;
          $display("FAIL p8_unexpected got=%h want=none", if8.p);
        end else begin
          logic [31:0] e;
          e = q8.pop_front();
          check("p8", 32'(if8.p), e);
          ret8 = e;
        end
      end else if (if8.busy) begin
        check("p8_hold", 32'(if8.p), ret8);
      end
    end
    rdy8_prev = if8.rdy;
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (if16.rdy && !rdy16_prev) begin
        if (q16.size() == 0) begin
          checks++; failures++;
          $display("FAIL p16_unexpected got=%h want=none", if16.p);
        end else begin
          logic [31:0] e;
          e = q16.pop_front();
          check("p16", if16.p, e);
          ret16 = e;
        end
      end else if (if16.busy) begin
        check("p16_hold", if16.p, ret16);
      end
    end
    rdy16_prev = if16.rdy;
  end

  // poke: drive a second start (a=2,b=2) two cycles after accept; it must be ignored.
  task automatic op8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                     input logic clr, input logic use_want, input logic [31:0] want,
                     input logic poke);
    logic [31:0] m;
    int lat, bc;
    m = ref_prod(8, sm, 16'(a), 16'(b));
`ifdef MULTI_BOOTH_ACC_EN
    m = ((clr ? 32'd0 : pm8) + m) & 32'h0000_FFFF;
`endif
    pm8 = m;
    @(negedge clk);
    if8.start = 1'b1; if8.signed_mode = sm; if8.a = a; if8.b = b;
`ifdef MULTI_BOOTH_ACC_EN
    if8.acc_clr = clr;
`endif
    q8.push_back(use_want ? want : m);
    @(negedge clk);
    if8.start = 1'b0;
    if8.a = 8'($urandom); if8.b = 8'($urandom); if8.signed_mode = 1'($urandom);
`ifdef MULTI_BOOTH_ACC_EN
    if8.acc_clr = 1'($urandom);
`endif
    lat = 0; bc = 0;
    while (!if8.rdy && lat < 64) begin
      if (if8.busy) bc++;
      @(negedge clk);
      lat++;
      if (poke && lat == 1) begin
        if8.start = 1'b1; if8.signed_mode = 1'b1; if8.a = 8'd2; if8.b = 8'd2;
      end else if (poke && lat == 2) begin
        if8.start = 1'b0;
      end
    end
    check("lat8", 32'(lat), 32'd5);
    check("busy8_cycles", 32'(bc), 32'd5);
    check("busy8_done", 32'(if8.busy), 32'd0);
  endtask

  task automatic op16(input logic sm, input logic [15:0] a, input logic [15:0] b,
                      input logic clr, input logic use_want, input logic [31:0] want);
    logic [31:0] m;
    int lat, bc;
    m = ref_prod(16, sm, a, b);
`ifdef MULTI_BOOTH_ACC_EN
    m = (clr ? 32'd0 : pm16) + m;
`endif
    pm16 = m;
    @(negedge clk);
    if16.start = 1'b1; if16.signed_mode = sm; if16.a = a; if16.b = b;
`ifdef MULTI_BOOTH_ACC_EN
    if16.acc_clr = clr;
`endif
    q16.push_back(use_want ? want : m);
    @(negedge clk);
    if16.start = 1'b0;
    if16.a = 16'($urandom); if16.b = 16'($urandom); if16.signed_mode = 1'($urandom);
    lat = 0; bc = 0;
    while (!if16.rdy && lat < 64) begin
      if (if16.busy) bc++;
      @(negedge clk);
      lat++;
    end
    check("lat16", 32'(lat), 32'd9);
    check("busy16_cycles", 32'(bc), 32'd9);
  endtask

  // Start signed 100*-3, then pull reset_n during the third RUN cycle.
  task automatic reset_mid8();
    @(negedge clk);
    if8.start = 1'b1; if8.signed_mode = 1'b1; if8.a = 8'd100; if8.b = 8'hFD;
`ifdef MULTI_BOOTH_ACC_EN
    if8.acc_clr = 1'b1;
`endif
    @(posedge clk);          // accept edge
    @(negedge clk);
    if8.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_p", 32'(if8.p), 32'd0);
    check("rst_mid_rdy", 32'(if8.rdy), 32'd0);
    check("rst_mid_busy", 32'(if8.busy), 32'd0);
    ret8 = '0; pm8 = '0; ret16 = '0; pm16 = '0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    if8.start = 1'b0;  if8.signed_mode = 1'b0;  if8.a = '0;  if8.b = '0;
    if16.start = 1'b0; if16.signed_mode = 1'b0; if16.a = '0; if16.b = '0;
`ifdef MULTI_BOOTH_ACC_EN
    if8.acc_clr = 1'b0; if16.acc_clr = 1'b0;
`endif
    ret8 = '0; ret16 = '0; pm8 = '0; pm16 = '0;
    rdy8_prev = 1'b0; rdy16_prev = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_p8", 32'(if8.p), 32'd0);
    check("rst_rdy8", 32'(if8.rdy), 32'd0);
    check("rst_busy8", 32'(if8.busy), 32'd0);
    check("rst_p16", if16.p, 32'd0);
    check("rst_rdy16", 32'(if16.rdy), 32'd0);
    check("rst_busy16", 32'(if16.busy), 32'd0);
    reset_n = 1'b1;

    op8(1'b1, 8'h80, 8'h80, 1'b1, 1'b1, 32'h4000, 1'b0);
    op8(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1, 32'hFE01, 1'b0);
    op8(1'b1, 8'hFF, 8'h05, 1'b1, 1'b1, 32'hFFFB, 1'b0);
    op8(1'b1, 8'd7,  8'd9,  1'b1, 1'b1, 32'h003F, 1'b1);
    op8(1'b1, 8'd2,  8'd2,  1'b1, 1'b1, 32'h0004, 1'b0);
    reset_mid8();
    op8(1'b1, 8'd12, 8'd12, 1'b0, 1'b1, 32'h0090, 1'b0);
    op16(1'b1, 16'h8000, 16'h7FFF, 1'b1, 1'b1, 32'hC000_8000);
    op8(1'b0, 8'd3, 8'd4, 1'b1, 1'b1, 32'h000C, 1'b0);
`ifdef MULTI_BOOTH_ACC_EN
    op8(1'b0, 8'd5, 8'd6, 1'b0, 1'b1, 32'h002A, 1'b0);
`else
    op8(1'b0, 8'd5, 8'd6, 1'b0, 1'b1, 32'h001E, 1'b0);
`endif

    for (int i = 0; i < 1200; i++)
      op8(1'($urandom), 8'(pick(8)), 8'(pick(8)), 1'($urandom), 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 1200; i++)
      op16(1'($urandom), pick(16), pick(16), 1'($urandom), 1'b0, 32'd0);

    repeat (3) @(negedge clk);
    check("q8_drained", 32'(q8.size()), 32'd0);
    check("q16_drained", 32'(q16.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
